light_sched: RTL and testbench
==============================

# light_sched

Parametrised, sequential successor to the combinational intersection light controller. It latches approach requests and grants one direction at a time in round-robin order. Each green is held between minimum and maximum times, and an all-Stop clearance interval separates grants until the intersection centre is empty. It sits per intersection between the simulator's sensor bus and the four light outputs, using the same 3-bit light encoding.

## Interface
Parameters:
- MIN_GREEN, 4: minimum cycles a granted direction holds Go (≥1)
- MAX_GREEN, 16: cycles after which green is forced off if another direction is pending (≥ MIN_GREEN)
- CLEAR_CYCLES, 2: minimum all-Stop cycles between greens (≥1)
- CNT_W, 8: phase counter width; must hold MAX_GREEN
- IDLE_GO, 1: 1 = all four Go when nothing is pending; 0 = all Stop

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- sensor_light  in  8  [0..3] centre cells; [4] southbound approach; [5] eastbound; [6] northbound; [7] westbound
- general_sensors  in  32  reserved; ignored
- outN, outS, outE, outW  out  3 each  light codes: Stop=000, Forward_only=001, Left_only=010, Right_only=011, Go=100
- phase  out  2  IDLE=0, GREEN=1, CLEAR=2
- active_dir  out  2  granted direction: N=0, E=1, S=2, W=3; 0 when not GREEN

## Operation
- Direction index order: N(sensor 6), E(5), S(4), W(7).
- centre_clear = sensor_light[3:0] == 0.
- pending[d] = req_q[d] | approach sensor d.
- req_q[d] sets whenever approach sensor d = 1. It clears on the edge d is granted. It does not set while d is GREEN.
- Arbiter: picks the first pending direction at or after rr_ptr in the cyclic order N→E→S→W. On each grant, rr_ptr = granted+1 mod 4.
- IDLE: outputs all Go (IDLE_GO=1) or all Stop (IDLE_GO=0).
  - IDLE_GO=1 and any pending → CLEAR.
  - IDLE_GO=0, any pending and centre_clear → GREEN with the arbiter pick.
- GREEN(d): out of d = Go, others Stop. cnt counts from 0, saturating at 2^CNT_W-1. Exit to CLEAR when either:
  - cnt ≥ MIN_GREEN-1 and sensor d = 0, or
  - cnt ≥ MAX_GREEN-1 and some other direction is pending.
  - Otherwise hold. With no competitor and the sensor held high, GREEN never ends.
- CLEAR: all Stop, cnt from 0. Exit when cnt ≥ CLEAR_CYCLES-1 and centre_clear:
  - any pending → GREEN(arbiter pick);
  - none pending → IDLE.
  - An occupied centre holds CLEAR indefinitely.
- Reset: state IDLE, all outputs Stop, phase 0, active_dir 0, rr_ptr 0 (N), req_q 0, cnt 0. Reset mid-phase abandons the grant and drops all latched requests.

## Timing
- Outputs, phase and active_dir are registered. They are computed from next state and update on the same edge as the state register.
- Sensor high sampled at edge k in IDLE (IDLE_GO=0, centre clear) → Go on that direction after edge k (1-cycle latency).
- Green duration: MIN_GREEN ≤ Go cycles; with a competitor pending, Go cycles ≤ MAX_GREEN.
- All-Stop gap between two greens ≥ CLEAR_CYCLES cycles. Gap = CLEAR_CYCLES exactly if the centre is already clear.
- Simultaneous requests are resolved by rr_ptr only; sensor arrival order within a cycle is irrelevant.
- A request asserted for a single cycle is never lost: it is held in req_q until granted.

## Structure
- Package light_pkg: Stop/Forward_only/Left_only/Right_only/Go codes, phase enum, direction indices N/E/S/W, sensor-bit index constants.
- Sub-module rr_arb4: 4-bit pending vector plus 2-bit pointer in, one-hot/valid and encoded grant out; purely combinational.
- The top level holds the FSM, counter, req_q, rr_ptr and output registers.

## Test plan
All scenarios use defaults except where IDLE_GO is stated.
- Reset and idle: rst high 3 cycles → all Stop, phase 0. Release with IDLE_GO=1 and no sensors → all Go from the next edge.
- Single request (IDLE_GO=0): pulse sensor 6 for 1 cycle → outN=Go exactly 4 cycles, others Stop, then 2 all-Stop cycles, then IDLE all Stop.
- Round robin: hold sensors 4, 5, 6, 7 continuously → grants N, E, S, W, N, each 16 cycles Go with 2-cycle gaps.
- Centre occupancy: assert sensor 0 during CLEAR for 10 cycles while sensor 5 is pending → all Stop throughout; outE=Go on the edge after both sensor 0 drops and CLEAR_CYCLES has elapsed.
- Max-green preemption: hold sensor 6; at cycle 3 of its green pulse sensor 7 → N keeps Go through cycle 15, then CLEAR, then W=Go.
- Reset mid-GREEN: rst while outE=Go with req_q[N] set → all Stop, req_q cleared; with no sensors afterwards, no grant occurs.

Source files
------------

// File: rtl/light_pkg.sv
// Shared light codes, phase encoding and sensor/direction indices for the
// intersection light scheduler.
package light_pkg;

   typedef logic [2:0] light_t;

   localparam light_t LightStop    = 3'b000;
   localparam light_t LightForward = 3'b001;
   localparam light_t LightLeft    = 3'b010;
   localparam light_t LightRight   = 3'b011;
   localparam light_t LightGo      = 3'b100;

   typedef enum logic [1:0] {
      PhIdle  = 2'd0,
      PhGreen = 2'd1,
      PhClear = 2'd2
   } phase_e;

   // Direction index order used by req/pending vectors and the arbiter.
   localparam logic [1:0] DirN = 2'd0;
   localparam logic [1:0] DirE = 2'd1;
   localparam logic [1:0] DirS = 2'd2;
   localparam logic [1:0] DirW = 2'd3;

   localparam int unsigned SensS = 4;
   localparam int unsigned SensE = 5;
   localparam int unsigned SensN = 6;
   localparam int unsigned SensW = 7;

endpackage

// File: rtl/light_sched_if.sv
// Sensor bus in, four light outputs plus phase/grant status out.
interface light_sched_if;
   import light_pkg::*;

   logic [7:0]  sensor_light;
   logic [31:0] general_sensors;
   light_t      outN;
   light_t      outS;
   light_t      outE;
   light_t      outW;
   logic [1:0]  phase;
   logic [1:0]  active_dir;

   modport master (
      output sensor_light, general_sensors,
      input  outN, outS, outE, outW, phase, active_dir
   );

   modport slave (
      input  sensor_light, general_sensors,
      output outN, outS, outE, outW, phase, active_dir
   );

endinterface

// File: rtl/rr_arb4.sv
// Four-way round-robin pick: first requester at or after ptr, cyclically.
module rr_arb4 (
   input  logic [3:0] req,
   input  logic [1:0] ptr,
   output logic [3:0] gnt,
   output logic       valid,
   output logic [1:0] idx
);

   logic [1:0] cand;

   always_comb begin
      valid = 1'b0;
      idx   = 2'd0;
      cand  = 2'd0;
      for (int i = 0; i < 4; i++) begin
         cand = ptr + i[1:0];
         if (!valid && req[cand]) begin
            valid = 1'b1;
            idx   = cand;
         end
      end
      gnt = valid ? (4'b0001 << idx) : 4'b0000;
   end

endmodule

// File: rtl/light_sched.sv
// Per-intersection light scheduler: latches approach requests and grants one
// direction at a time round-robin, with min/max green and all-Stop clearance.
module light_sched
   import light_pkg::*;
#(
   parameter int unsigned MIN_GREEN    = 4,
   parameter int unsigned MAX_GREEN    = 16,
   parameter int unsigned CLEAR_CYCLES = 2,
   parameter int unsigned CNT_W        = 8,
   parameter bit          IDLE_GO      = 1'b1
) (
   input logic          clk,
   input logic          rst,
   light_sched_if.slave bus
);

   localparam logic [CNT_W-1:0] MinLast = CNT_W'(MIN_GREEN - 1);
   localparam logic [CNT_W-1:0] MaxLast = CNT_W'(MAX_GREEN - 1);
   localparam logic [CNT_W-1:0] ClrLast = CNT_W'(CLEAR_CYCLES - 1);
   localparam logic [CNT_W-1:0] CntMax  = '1;

   phase_e            state_q, state_d;
   logic [1:0]        dir_q, dir_d;
   logic [1:0]        rr_ptr_q, rr_ptr_d;
   logic [3:0]        req_q, req_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [3:0][2:0]   lights_q, lights_d;
   logic [1:0]        active_dir_q, active_dir_d;

   logic [3:0] approach, pending, others, gnt_oh;
   logic       centre_clear, arb_valid, grant;
   logic [1:0] arb_idx;
   logic       unused_general;

   assign approach = {bus.sensor_light[SensW], bus.sensor_light[SensS],
                      bus.sensor_light[SensE], bus.sensor_light[SensN]};
   assign centre_clear   = (bus.sensor_light[3:0] == 4'b0000);
   assign pending        = req_q | approach;
   assign others         = pending & ~(4'b0001 << dir_q);
   assign unused_general = ^bus.general_sensors;

   rr_arb4 u_arb (
      .req   (pending),
      .ptr   (rr_ptr_q),
      .gnt   (gnt_oh),
      .valid (arb_valid),
      .idx   (arb_idx)
   );

   always_comb begin
      state_d  = state_q;
      dir_d    = dir_q;
      rr_ptr_d = rr_ptr_q;
      grant    = 1'b0;
      unique case (state_q)
         PhIdle: begin
            if (IDLE_GO) begin
               if (|pending) state_d = PhClear;
            end else if (|pending && centre_clear) begin
               grant = arb_valid;
            end
         end
         PhGreen: begin
            if ((cnt_q >= MinLast && !approach[dir_q]) || (cnt_q >= MaxLast && |others)) begin
               state_d = PhClear;
            end
         end
         PhClear: begin
            if (cnt_q >= ClrLast && centre_clear) begin
               if (|pending) grant = arb_valid;
               else          state_d = PhIdle;
            end
         end
         default: state_d = PhIdle;
      endcase

      if (grant) begin
         state_d  = PhGreen;
         dir_d    = arb_idx;
         rr_ptr_d = arb_idx + 2'd1;
      end

      if (state_d != state_q) cnt_d = '0;
      else if (cnt_q == CntMax) cnt_d = cnt_q;
      else cnt_d = cnt_q + 1'b1;

      // The granted direction drops its latch; the green one never re-latches.
      for (int d = 0; d < 4; d++) begin
         req_d[d] = (req_q[d] | (approach[d] & !(state_q == PhGreen && dir_q == d[1:0])))
                    & !(grant && gnt_oh[d]);
      end

      for (int d = 0; d < 4; d++) begin
         unique case (state_d)
            PhGreen: lights_d[d] = (dir_d == d[1:0]) ? LightGo : LightStop;
            PhIdle:  lights_d[d] = IDLE_GO ? LightGo : LightStop;
            default: lights_d[d] = LightStop;
         endcase
      end
      active_dir_d = (state_d == PhGreen) ? dir_d : 2'd0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= PhIdle;
         dir_q        <= DirN;
         rr_ptr_q     <= DirN;
         req_q        <= '0;
         cnt_q        <= '0;
         lights_q     <= '0;
         active_dir_q <= 2'd0;
      end else begin
         state_q      <= state_d;
         dir_q        <= dir_d;
         rr_ptr_q     <= rr_ptr_d;
         req_q        <= req_d;
         cnt_q        <= cnt_d;
         lights_q     <= lights_d;
         active_dir_q <= active_dir_d;
      end
   end

   assign bus.outN       = lights_q[DirN];
   assign bus.outE       = lights_q[DirE];
   assign bus.outS       = lights_q[DirS];
   assign bus.outW       = lights_q[DirW];
   assign bus.phase      = state_q;
   assign bus.active_dir = active_dir_q;

endmodule

// File: tb/tb_light_sched.sv
// Bench for light_sched: one instance with IDLE_GO=0 and one with IDLE_GO=1,
// vector table plus hand-written multi-cycle sequences with a scoreboard.
module tb_light_sched;
   import light_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   light_sched_if if0 ();
   light_sched_if if1 ();

   light_sched #(.IDLE_GO(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
   light_sched #(.IDLE_GO(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

   int checks = 0;
   int errors = 0;
   string tag = "";
   logic [15:0] q0[$];
   logic [15:0] q1[$];

   typedef struct {
      logic [7:0]  sens;
      logic [15:0] exp;
   } vec_t;
   vec_t tbl[9];

   // Packed view: {phase, active_dir, outN, outE, outS, outW}
   localparam logic [15:0] Idle0 = 16'h0000;
   localparam logic [15:0] Idle1 = {4'h0, LightGo, LightGo, LightGo, LightGo};
   localparam logic [15:0] Clr   = {2'd2, 2'd0, 12'h000};

   function automatic logic [15:0] green(input logic [1:0] d);
      return {2'd1, d,
              (d == 2'd0) ? LightGo : LightStop,
              (d == 2'd1) ? LightGo : LightStop,
              (d == 2'd2) ? LightGo : LightStop,
              (d == 2'd3) ? LightGo : LightStop};
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s/%s: got %h expected %h", tag, name, act, exp);
      end
   endtask

   task automatic cyc(input logic [7:0] s0, input logic [15:0] e0,
                      input logic [7:0] s1, input logic [15:0] e1, input bit c1);
      if0.sensor_light = s0;
      if1.sensor_light = s1;
      q0.push_back(e0);
      if (c1) q1.push_back(e1);
      @(posedge clk);
      @(negedge clk);
      check("dut0", {if0.phase, if0.active_dir, if0.outN, if0.outE, if0.outS, if0.outW},
            q0.pop_front());
      if (q1.size() != 0)
         check("dut1", {if1.phase, if1.active_dir, if1.outN, if1.outE, if1.outS, if1.outW},
               q1.pop_front());
   endtask

   task automatic c0(input logic [7:0] s0, input logic [15:0] e0);
      cyc(s0, e0, 8'h00, Idle0, 1'b0);
   endtask

   task automatic wait_idle();
      int n = 0;
      if0.sensor_light = 8'h00;
      if1.sensor_light = 8'h00;
      while (if0.phase != 2'd0 && n < 100) begin
         @(posedge clk);
         @(negedge clk);
         n++;
      end
      check("wait_idle", {14'd0, if0.phase}, 16'd0);
   endtask

   initial begin
      tbl[0] = '{8'h40, green(DirN)};
      tbl[1] = '{8'h80, green(DirW)};
      tbl[2] = '{8'h10, green(DirS)};
      tbl[3] = '{8'h20, green(DirE)};
      tbl[4] = '{8'h50, green(DirS)};
      tbl[5] = '{8'hA0, green(DirE)};
      tbl[6] = '{8'hF0, green(DirN)};
      tbl[7] = '{8'h90, green(DirS)};
      tbl[8] = '{8'h0F, Idle0};

      if0.general_sensors = $urandom();
      if1.general_sensors = $urandom();
      if0.sensor_light = 8'h00;
      if1.sensor_light = 8'h00;

      tag = "reset";
      repeat (3) cyc(8'h00, Idle0, 8'h00, Idle0, 1'b1);
      rst = 1'b0;
      tag = "idle_go";
      repeat (2) cyc(8'h00, Idle0, 8'h00, Idle1, 1'b1);

      tag = "round_robin";
      repeat (2) cyc(8'h00, Idle0, 8'hF0, Clr, 1'b1);
      for (int d = 0; d < 4; d++) begin
         repeat (16) cyc(8'h00, Idle0, 8'hF0, green(d[1:0]), 1'b1);
         repeat (2) cyc(8'h00, Idle0, 8'hF0, Clr, 1'b1);
      end
      repeat (16) cyc(8'h00, Idle0, 8'hF0, green(DirN), 1'b1);

      tag = "table";
      for (int i = 0; i < 9; i++) begin
         cyc(tbl[i].sens, tbl[i].exp, 8'h00, Idle0, 1'b0);
         wait_idle();
      end

      tag = "single";
      c0(8'h40, green(DirN));
      repeat (3) c0(8'h00, green(DirN));
      repeat (2) c0(8'h00, Clr);
      repeat (2) c0(8'h00, Idle0);

      tag = "centre";
      c0(8'h40, green(DirN));
      c0(8'h20, green(DirN));
      repeat (2) c0(8'h00, green(DirN));
      c0(8'h00, Clr);
      repeat (10) c0(8'h01, Clr);
      c0(8'h00, green(DirE));
      repeat (3) c0(8'h00, green(DirE));
      repeat (2) c0(8'h00, Clr);
      c0(8'h00, Idle0);

      tag = "preempt";
      repeat (3) c0(8'h40, green(DirN));
      c0(8'hC0, green(DirN));
      repeat (12) c0(8'h40, green(DirN));
      repeat (2) c0(8'h40, Clr);
      c0(8'h40, green(DirW));
      repeat (3) c0(8'h00, green(DirW));
      repeat (2) c0(8'h00, Clr);
      repeat (4) c0(8'h00, green(DirN));
      repeat (2) c0(8'h00, Clr);
      c0(8'h00, Idle0);

      tag = "reset_mid";
      c0(8'h20, green(DirE));
      c0(8'h40, green(DirE));
      c0(8'h00, green(DirE));
      rst = 1'b1;
      c0(8'h00, Idle0);
      rst = 1'b0;
      repeat (20) c0(8'h00, Idle0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
